speck_key_expander: RTL and testbench
=====================================

SPECK_KEY_EXPANDER -- requirements
Module: speck_key_expander

Interface
REQ-001 Parameter W, default 32, word width in bits.
REQ-002 Parameter ROUNDS, default 27, number of round keys produced.
REQ-003 Parameter M, default 4, number of key words.
REQ-004 Parameter ALPHA, default 8, right-rotate amount.
REQ-005 Parameter BETA, default 3, left-rotate amount.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  request to expand key; sampled on every rising edge.
REQ-009 key  in  W*M  master key: bits [W-1:0]=k0, [2W-1:W]=l0, [3W-1:2W]=l1, [4W-1:3W]=l2.
REQ-010 rk_flat  out  W*ROUNDS  registered round keys; slot i is bits [i*W +: W]; directly feeds the encryptor's rk_flat port.
REQ-011 busy  out  1  expansion in progress.
REQ-012 done  out  1  one-cycle pulse on completion.
REQ-013 rk_valid  out  1  level; all ROUNDS slots of rk_flat are valid for the last accepted key.

Function
REQ-014 States: IDLE (busy=0) and RUN (busy=1); RUN entered only from IDLE on start=1.
REQ-015 Start acceptance edge (IDLE, start=1): write rk_flat slot 0 = k0, load k=k0, load l-queue {l0,l1,l2}, i=0, busy=1, rk_valid=0, done=0.
REQ-016 start while busy=1 ignored; key not re-sampled; no restart.
REQ-017 Each RUN edge: lnew = (k + ROR(l_head, ALPHA)) ^ i; knew = ROL(k, BETA) ^ lnew; k=knew; shift l-queue (drop head, append lnew); write slot i+1 = knew; i=i+1.
REQ-018 Addition modulo 2^W, carry discarded; i zero-extended to W bits before XOR.
REQ-019 Edge writing slot ROUNDS-1: busy=0, done=1, rk_valid=1 on that same edge; return to IDLE.
REQ-020 Latency: done high exactly ROUNDS-1 cycles (26 by default) after the start acceptance edge.
REQ-021 done high for exactly one cycle, then 0 unless a new completion occurs.
REQ-022 start=1 in the cycle done=1 (busy=0) accepted as a new expansion; rk_valid drops on that edge.
REQ-023 Slots not yet rewritten hold previous contents during RUN; rk_valid=0 marks them stale.
REQ-024 Counter i wide enough for ROUNDS-1 (6 bits for default); no wrap within a run.
REQ-025 ROUNDS=1: done and rk_valid asserted on the start acceptance edge, with slot 0 = k0.

Reset
REQ-026 rst=1 clears rk_flat, k, l-queue, i, busy, done and rk_valid to 0 immediately, independent of clk.
REQ-027 rst during RUN aborts the expansion; no done pulse; next start after release begins a fresh run.

Structure
REQ-028 Package speck_pkg holds W, ROUNDS, M, ALPHA, BETA defaults, shared with the encryptor.
REQ-029 Single sub-module: existing speck_round, instanced with x_in=l_head, y_in=k, k_in=i; x_out=lnew, y_out=knew. No duplicated round logic.

Verification
REQ-030 Reset, then key=0x1b1a1918_13121110_0b0a0908_03020100, start one cycle -> slot0=0x03020100, slot1=0x131d0309, done pulse 26 cycles after acceptance, rk_valid=1.
REQ-031 Same key, chained to encryptor with pt_x=0x3b726574, pt_y=0x7475432d -> ct_x=0x8c6fa548, ct_y=0x454e028b.
REQ-032 Pulse start with a different key at cycles 3 and 10 of a run -> run unaffected, result equals golden model for the first key only.
REQ-033 start held high continuously -> back-to-back runs, new acceptance on each done cycle, done period 27 cycles.
REQ-034 Assert rst at cycle 12 of a run -> all outputs 0 asynchronously, no done pulse; after release a new start completes correctly.
REQ-035 200 random keys vs. software golden model -> every rk_flat slot matches.

Source files
------------

// File: rtl/speck_pkg.sv
// Speck shared definitions: default geometry of the 64/128 variant and the
// key-expander state encoding, common to the expander and the encryptor.
package speck_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_ROUNDS = 27;
    localparam int DEF_M      = 4;
    localparam int DEF_ALPHA  = 8;
    localparam int DEF_BETA   = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } exp_state_t;

endpackage

// File: rtl/speck_round.sv
// One Speck round: x' = (ROR(x,ALPHA) + y) ^ k ; y' = ROL(y,BETA) ^ x'.
// Shared by the encryptor datapath and the key expander.
module speck_round
    import speck_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ALPHA = DEF_ALPHA,
    parameter int BETA  = DEF_BETA
) (
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] k_in,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out
);

    logic [W-1:0] x_ror;
    logic [W-1:0] y_rol;

    always_comb begin
        x_ror = (x_in >> ALPHA) | (x_in << (W - ALPHA));
        y_rol = (y_in << BETA) | (y_in >> (W - BETA));
        x_out = (x_ror + y_in) ^ k_in;
        y_out = y_rol ^ x_out;
    end

endmodule

// File: rtl/speck_key_expander.sv
// Speck key schedule: one round key per clock into a registered rk_flat bank
// that feeds the encryptor directly; done pulses when the last slot lands.
module speck_key_expander
    import speck_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int M      = DEF_M,
    parameter int ALPHA  = DEF_ALPHA,
    parameter int BETA   = DEF_BETA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W*M-1:0]      key,
    output logic [W*ROUNDS-1:0] rk_flat,
    output logic                busy,
    output logic                done,
    output logic                rk_valid
);

    // One spare bit so the counter can hold ROUNDS-1 without wrapping.
    localparam int             IW     = $clog2(ROUNDS) + 1;
    localparam logic [IW-1:0]  LAST_I = IW'(ROUNDS > 1 ? ROUNDS - 2 : 0);

    exp_state_t            state;
    exp_state_t            next_state;
    logic [W-1:0]          k;
    logic [M-2:0][W-1:0]   l_q;
    logic [IW-1:0]         i;
    logic [W-1:0]          round_idx;
    logic [W-1:0]          lnew;
    logic [W-1:0]          knew;
    logic                  accept;
    logic                  last_step;

    speck_round #(
        .W     (W),
        .ALPHA (ALPHA),
        .BETA  (BETA)
    ) u_round (
        .x_in  (l_q[0]),
        .y_in  (k),
        .k_in  (round_idx),
        .x_out (lnew),
        .y_out (knew)
    );

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start && ROUNDS > 1) next_state = S_RUN;
            S_RUN:  if (i == LAST_I)        next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_RUN);
        accept    = (state == S_IDLE) && start;
        last_step = (state == S_RUN) && (i == LAST_I);
        round_idx = W'(i);
    end

    // NOTE: rk_flat is a flop bank rather than a RAM, so it takes the async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_flat  <= '0;
            k        <= '0;
            l_q      <= '0;
            i        <= '0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
        end else if (accept) begin
            rk_flat[W-1:0] <= key[W-1:0];
            k              <= key[W-1:0];
            for (int j = 0; j < M - 1; j++) l_q[j] <= key[(j+1)*W +: W];
            i        <= '0;
            done     <= (ROUNDS == 1);
            rk_valid <= (ROUNDS == 1);
        end else if (state == S_RUN) begin
            k <= knew;
            for (int j = 0; j < M - 2; j++) l_q[j] <= l_q[j+1];
            l_q[M-2] <= lnew;
            rk_flat[(int'(i) + 1) * W +: W] <= knew;
            i        <= i + 1'b1;
            done     <= last_step;
            rk_valid <= last_step;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_speck_key_expander.sv
// Randomized self-checking bench for speck_key_expander against a plain
// software model of the Speck 64/128 key schedule and cipher.
module tb_speck_key_expander;

    localparam int W  = 32;
    localparam int R  = 27;
    localparam int M  = 4;
    localparam int FW = W * R;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W*M-1:0]  key;
    logic [FW-1:0]   rk_flat;
    logic            busy;
    logic            done;
    logic            rk_valid;

    int n_vec;
    int n_bad;

    speck_key_expander dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .rk_flat  (rk_flat),
        .busy     (busy),
        .done     (done),
        .rk_valid (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] ror(input bit [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic bit [31:0] rol(input bit [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Key schedule straight from the Speck definition, with l kept as a queue.
    function automatic logic [FW-1:0] golden(input logic [W*M-1:0] mk);
        logic [FW-1:0] flat;
        bit [31:0]     kk;
        bit [31:0]     ln;
        bit [31:0]     lq[$];
        flat = '0;
        kk   = mk[31:0];
        lq   = {mk[63:32], mk[95:64], mk[127:96]};
        flat[31:0] = kk;
        for (int r = 0; r < R - 1; r++) begin
            ln = (kk + ror(lq[0], 8)) ^ 32'(r);
            kk = rol(kk, 3) ^ ln;
            void'(lq.pop_front());
            lq.push_back(ln);
            flat[(r+1)*32 +: 32] = kk;
        end
        return flat;
    endfunction

    function automatic logic [63:0] encrypt(input logic [FW-1:0] rks, input bit [31:0] px, input bit [31:0] py);
        bit [31:0] x;
        bit [31:0] y;
        x = px;
        y = py;
        for (int r = 0; r < R; r++) begin
            x = (ror(x, 8) + y) ^ rks[r*32 +: 32];
            y = rol(y, 3) ^ x;
        end
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done with a cycle budget; returns edges elapsed.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic expand(input string tag, input logic [W*M-1:0] mk);
        int lat;
        key   = mk;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, FW'(busy), FW'(1));
        wait_done(lat);
        check({tag, "_lat"}, FW'(lat), FW'(26));
        check({tag, "_rk"}, rk_flat, golden(mk));
        tick();
        check({tag, "_pulse"}, FW'({done, rk_valid, busy}), FW'(3'b010));
    endtask

    localparam logic [127:0] KEY0 = 128'h1b1a1918_13121110_0b0a0908_03020100;

    initial begin
        int lat;
        int done_seen;
        logic [127:0] k1;
        logic [127:0] k2;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;
        tick();
        tick();
        check("reset_rk", rk_flat, '0);
        check("reset_ctl", FW'({busy, done, rk_valid}), FW'(0));
        rst = 1'b0;
        tick();

        // Published test vector: first two round keys, latency and cipher output.
        key   = KEY0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("vec_slot0", FW'(rk_flat[31:0]), FW'(32'h03020100));
        check("vec_valid_low", FW'(rk_valid), FW'(0));
        tick();
        check("vec_slot1", FW'(rk_flat[63:32]), FW'(32'h131d0309));
        wait_done(lat);
        check("vec_lat", FW'(lat + 1), FW'(26));
        check("vec_valid", FW'({rk_valid, busy}), FW'(2'b10));
        check("vec_rk", rk_flat, golden(KEY0));
        check("vec_ct", FW'(encrypt(rk_flat, 32'h3b726574, 32'h7475432d)),
              FW'(64'h8c6fa548_454e028b));
        tick();
        check("vec_done_drop", FW'(done), FW'(0));

        // start pulses with another key mid-run must be ignored.
        k1    = {$urandom(), $urandom(), $urandom(), $urandom()};
        k2    = ~k1;
        key   = k1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3 || c == 10) begin
                key   = k2;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        wait_done(lat);
        check("ign_lat", FW'(lat + 10), FW'(26));
        check("ign_rk", rk_flat, golden(k1));
        tick();

        // start held high: a new run is accepted on each done cycle.
        key   = k1;
        start = 1'b1;
        tick();
        wait_done(lat);
        check("hold_lat0", FW'(lat), FW'(26));
        check("hold_rk0", rk_flat, golden(k1));
        key = k2;
        tick();
        check("hold_restart", FW'({busy, done, rk_valid}), FW'(3'b100));
        wait_done(lat);
        check("hold_period", FW'(lat + 1), FW'(27));
        check("hold_rk1", rk_flat, golden(k2));
        key = KEY0;
        tick();
        wait_done(lat);
        check("hold_period2", FW'(lat + 1), FW'(27));
        check("hold_rk2", rk_flat, golden(KEY0));
        start = 1'b0;
        tick();
        check("hold_stop", FW'({busy, done, rk_valid}), FW'(3'b001));

        // Asynchronous reset in the middle of a run.
        key   = k2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_rk", rk_flat, '0);
        check("arst_ctl", FW'({busy, done, rk_valid}), FW'(0));
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) done_seen++;
        end
        check("arst_nodone", FW'(done_seen), FW'(0));
        expand("arst_after", k1);

        // Random keys against the model.
        for (int n = 0; n < 200; n++) begin
            expand("rand", {$urandom(), $urandom(), $urandom(), $urandom()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
